// File: rtl/sum_accumulator.sv
// sum_accumulator: frames a stream of Width-bit unsigned samples into groups of
// up to Count samples and presents each frame's total and sample count.
//
// Ports:
//   iClk    - clock, rising edge
//   iRst    - synchronous reset, active-high
//   iValid  - iData holds a valid sample
//   oReady  - block accepts a sample this cycle (high while accumulating)
//   iData   - unsigned sample
//   iFlush  - close the current frame after this cycle's sample, if any
//   oValid  - oTotal/oNum hold a completed frame
//   iReady  - consumer accepts the frame
//   oTotal  - unsigned sum of the frame's samples
//   oNum    - number of samples in the frame (1..Count)
module sum_accumulator #(
    parameter int unsigned Width    = 8,
    parameter int unsigned Count    = 4,
    // Derived; wide enough that Count full-scale samples never overflow.
    parameter int unsigned OutWidth = Width + $clog2(Count)
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic [Width-1:0]             iData,
    input  logic                         iFlush,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [OutWidth-1:0]          oTotal,
    output logic [$clog2(Count+1)-1:0]   oNum
);

    localparam int unsigned          NumWidth = $clog2(Count + 1);
    localparam logic [NumWidth-1:0]  CountVal = NumWidth'(Count);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e                state_q, state_d;
    logic [OutWidth-1:0]   acc_q, acc_d;
    logic [NumWidth-1:0]   cnt_q, cnt_d;
    logic [OutWidth-1:0]   total_q, total_d;
    logic [NumWidth-1:0]   num_q, num_d;

    logic                  accept;
    logic                  close;
    logic [OutWidth-1:0]   acc_sum;
    logic [NumWidth-1:0]   cnt_sum;

    // Running values including this cycle's sample, if it is taken.
    assign accept  = iValid && (state_q == StAccum);
    assign acc_sum = acc_q + (accept ? OutWidth'(iData) : '0);
    assign cnt_sum = cnt_q + (accept ? NumWidth'(1) : '0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        num_d   = num_q;
        close   = 1'b0;

        unique case (state_q)
            StAccum: begin
                // A flush with nothing collected and nothing arriving is a no-op,
                // so an empty frame is never produced.
                close = (accept && (cnt_sum == CountVal)) ||
                        (iFlush && ((cnt_q != '0) || accept));
                if (close) begin
                    total_d = acc_sum;
                    num_d   = cnt_sum;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_sum;
                end
            end
            StHold: begin
                // Result stays put; sample inputs are ignored until the consumer takes it.
                if (iReady) begin
                    state_d = StAccum;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            num_q   <= num_d;
        end
    end

    // Handshake outputs come straight from state: no input-to-output paths.
    assign oReady = (state_q == StAccum);
    assign oValid = (state_q == StHold);
    assign oTotal = total_q;
    assign oNum   = num_q;

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // W=8, C=4 instance
    logic        v8, f8, r8, rdy8, ov8;
    logic [7:0]  d8;
    logic [9:0]  tot8;
    logic [2:0]  num8;
    // W=16, C=1 instance
    logic        v16, f16, r16, rdy16, ov16;
    logic [15:0] d16;
    logic [15:0] tot16;
    logic [0:0]  num16;

    int vectors     = 0;
    int miscompares = 0;

    sum_accumulator #(.Width(8), .Count(4)) u_dut8 (
        .iClk   (clk),
        .iRst   (rst),
        .iValid (v8),
        .oReady (rdy8),
        .iData  (d8),
        .iFlush (f8),
        .oValid (ov8),
        .iReady (r8),
        .oTotal (tot8),
        .oNum   (num8)
    );

    sum_accumulator #(.Width(16), .Count(1)) u_dut16 (
        .iClk   (clk),
        .iRst   (rst),
        .iValid (v16),
        .oReady (rdy16),
        .iData  (d16),
        .iFlush (f16),
        .oValid (ov16),
        .iReady (r16),
        .oTotal (tot16),
        .oNum   (num16)
    );

    typedef struct {
        longint unsigned total;
        longint unsigned num;
    } frame_t;

    frame_t q0[$];
    frame_t q1[$];

    // Reference model: list-of-samples view of the open frame plus a "result pending" flag.
    longint unsigned msum[2];
    int              mn[2];
    bit              mbusy[2];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            msum[i]  = 0;
            mn[i]    = 0;
            mbusy[i] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_step(int idx, int cmax, bit v, longint unsigned d, bit f,
                                       bit r);
        frame_t fr;
        if (mbusy[idx]) begin
            if (r) mbusy[idx] = 1'b0;
        end else begin
            if (v) begin
                msum[idx] += d;
                mn[idx]++;
            end
            if ((mn[idx] == cmax) || (f && (mn[idx] > 0))) begin
                fr.total = msum[idx];
                fr.num   = longint'(mn[idx]);
                if (idx == 0) q0.push_back(fr);
                else          q1.push_back(fr);
                msum[idx]  = 0;
                mn[idx]    = 0;
                mbusy[idx] = 1'b1;
            end
        end
    endfunction

    // One clock: inputs already set; check readiness, advance model across the edge.
    task automatic cycle();
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            chk("ready8", {63'd0, rdy8}, {63'd0, !mbusy[0]});
            chk("ready16", {63'd0, rdy16}, {63'd0, !mbusy[1]});
            model_step(0, 4, v8, longint'(d8), f8, r8);
            model_step(1, 1, v16, longint'(d16), f16, r16);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send8(logic [7:0] d);
        v8 = 1'b1;
        d8 = d;
        cycle();
        v8 = 1'b0;
    endtask

    // Monitor: compares each delivered frame against the scoreboard and checks hold stability.
    bit          hold0, hold1;
    logic [63:0] last_t0, last_n0, last_t1, last_n1;

    always @(negedge clk) begin
        frame_t fr;
        if (rst) begin
            hold0 = 1'b0;
            hold1 = 1'b0;
        end else begin
            if (ov8) begin
                if (hold0) begin
                    chk("hold_total8", 64'(tot8), last_t0);
                    chk("hold_num8", 64'(num8), last_n0);
                end
                if (r8) begin
                    if (q0.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame8: got unexpected frame total 0x%0h, expected none",
                                 tot8);
                    end else begin
                        fr = q0.pop_front();
                        chk("frame_total8", 64'(tot8), fr.total);
                        chk("frame_num8", 64'(num8), fr.num);
                    end
                    hold0 = 1'b0;
                end else begin
                    hold0   = 1'b1;
                    last_t0 = 64'(tot8);
                    last_n0 = 64'(num8);
                end
            end else begin
                hold0 = 1'b0;
            end

            if (ov16) begin
                if (hold1) begin
                    chk("hold_total16", 64'(tot16), last_t1);
                    chk("hold_num16", 64'(num16), last_n1);
                end
                if (r16) begin
                    if (q1.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame16: got unexpected frame total 0x%0h, expected none",
                                 tot16);
                    end else begin
                        fr = q1.pop_front();
                        chk("frame_total16", 64'(tot16), fr.total);
                        chk("frame_num16", 64'(num16), fr.num);
                    end
                    hold1 = 1'b0;
                end else begin
                    hold1   = 1'b1;
                    last_t1 = 64'(tot16);
                    last_n1 = 64'(num16);
                end
            end else begin
                hold1 = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        v8 = 1'b0; f8 = 1'b0; r8 = 1'b1; d8 = '0;
        v16 = 1'b0; f16 = 1'b0; r16 = 1'b1; d16 = '0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("rst_valid8", 64'(ov8), 0);
        chk("rst_total8", 64'(tot8), 0);
        chk("rst_num8", 64'(num8), 0);
        chk("rst_ready8", 64'(rdy8), 1);
        chk("rst_valid16", 64'(ov16), 0);
        chk("rst_ready16", 64'(rdy16), 1);

        // T1: 1,2,3,4 back to back -> 0x00A, 4, valid one cycle
        for (int i = 1; i <= 4; i++) send8(8'(i));
        chk("t1_valid", 64'(ov8), 1);
        chk("t1_total", 64'(tot8), 64'h00A);
        chk("t1_num", 64'(num8), 4);
        cycle();
        chk("t1_valid_drop", 64'(ov8), 0);

        // T2: four full-scale samples -> 0x3FC
        for (int i = 0; i < 4; i++) send8(8'hFF);
        chk("t2_total", 64'(tot8), 64'h3FC);
        chk("t2_num", 64'(num8), 4);
        cycle();

        // T3: 5,6 then a bare flush -> 0x0B, 2; then a flush on an empty frame does nothing
        send8(8'h05);
        send8(8'h06);
        f8 = 1'b1;
        cycle();
        f8 = 1'b0;
        chk("t3_valid", 64'(ov8), 1);
        chk("t3_total", 64'(tot8), 64'h00B);
        chk("t3_num", 64'(num8), 2);
        cycle();
        f8 = 1'b1;
        cycle();
        f8 = 1'b0;
        chk("t3_empty_flush", 64'(ov8), 0);

        // T4: backpressure for 5 cycles with sample traffic that must be ignored
        r8 = 1'b0;
        for (int i = 1; i <= 4; i++) send8(8'(i + 8));
        for (int i = 0; i < 5; i++) begin
            v8 = 1'b1;
            d8 = 8'($urandom);
            cycle();
            chk("t4_ready_low", 64'(rdy8), 0);
            chk("t4_valid_held", 64'(ov8), 1);
            chk("t4_total_held", 64'(tot8), 64'd42);
        end
        v8 = 1'b0;
        r8 = 1'b1;
        cycle();
        chk("t4_ready_back", 64'(rdy8), 1);
        chk("t4_valid_drop", 64'(ov8), 0);

        // T5: reset mid-frame discards the partial sum
        send8(8'h07);
        send8(8'h08);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send8(8'h01);
        chk("t5_total", 64'(tot8), 64'h004);
        chk("t5_num", 64'(num8), 4);
        cycle();

        // T6: Count=1 instance, one sample per frame
        v16 = 1'b1;
        d16 = 16'h1234;
        cycle();
        v16 = 1'b0;
        chk("t6_valid", 64'(ov16), 1);
        chk("t6_total", 64'(tot16), 64'h1234);
        chk("t6_num", 64'(num16), 1);
        cycle();

        // Random traffic on both instances, with occasional resets
        repeat (3000) begin
            rst = ($urandom_range(0, 499) == 0);
            v8  = ($urandom_range(0, 9) < 7);
            d8  = 8'($urandom);
            f8  = ($urandom_range(0, 9) == 0);
            r8  = ($urandom_range(0, 9) < 6);
            v16 = ($urandom_range(0, 9) < 7);
            d16 = 16'($urandom);
            f16 = ($urandom_range(0, 9) == 0);
            r16 = ($urandom_range(0, 9) < 6);
            cycle();
        end

        // Drain anything still pending
        rst = 1'b0;
        v8 = 1'b0; f8 = 1'b0; r8 = 1'b1;
        v16 = 1'b0; f16 = 1'b0; r16 = 1'b1;
        repeat (4) cycle();
        chk("drain8", 64'(q0.size()), 0);
        chk("drain16", 64'(q1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
